bootram_loader: RTL and testbench
=================================

# bootram_loader

Initiator-side companion to the 16-word boot RAM: accepts a stream of 32-bit instruction words, writes them into boot RAM addresses 0..N-1 over the RAM's req/wen/addr/data port, optionally reads them back and checks a running checksum, then raises a fetch-enable to release the core. It sits between the debug/UART word source and the boot RAM, and gates core start-up until the boot image is in place.

## Interface
Parameters:
- NUM_WORDS, 16, boot RAM depth in words (max load length).
- ADDR_W, 4, boot RAM address width; NUM_WORDS <= 2**ADDR_W.

Ports:
- clk_i  in  1  clock; all state on rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- start_i  in  1  begin a load; sampled only in IDLE and ERROR.
- len_i  in  ADDR_W+1  number of words to load; sampled with start_i.
- s_valid_i  in  1  input word valid.
- s_data_i  in  32  input word.
- s_ready_o  out  1  loader accepts a word this cycle.
- mem_req_o  out  1  boot RAM request.
- mem_wen_o  out  1  1 = write, 0 = read.
- mem_addr_o  out  ADDR_W  boot RAM word address.
- mem_data_o  out  32  write data.
- mem_rdata_i  in  32  boot RAM read data, valid one cycle after a read request.
- busy_o  out  1  load or verify in progress.
- done_o  out  1  image loaded (and verified); sticky until reset.
- error_o  out  1  verify mismatch; sticky until next start_i or reset.
- fetch_enable_o  out  1  core fetch release; high only in DONE.

## Operation
- All outputs registered. Reset value of every output: 0. State <- IDLE, counters and checksum <- 0.
- len_i clamping: eff_len = min(len_i, NUM_WORDS). eff_len = 0: IDLE -> DONE directly, no RAM access.
- States: IDLE, LOAD, VERIFY, CHECK, DONE, ERROR.
- IDLE: start_i with eff_len > 0 -> LOAD; wr_cnt <- 0, sum <- 0, error_o <- 0.
- LOAD: s_ready_o = 1 while wr_cnt < eff_len. Beat accepted (s_valid_i && s_ready_o) at edge k -> cycle k+1: mem_req_o=1, mem_wen_o=1, mem_addr_o=wr_cnt, mem_data_o=s_data_i; wr_cnt++, sum += s_data_i (32-bit, wrap modulo 2^32). No beat -> mem_req_o=0 next cycle. s_ready_o drops the cycle after the last beat is accepted.
- After the last write cycle: -> VERIFY (macro defined) or -> DONE (macro undefined).
- VERIFY: issue reads addr 0..eff_len-1 on consecutive cycles (mem_req_o=1, mem_wen_o=0, mem_data_o=0). Each mem_rdata_i sampled one cycle after its request, added into rsum. -> CHECK after last sample.
- CHECK (1 cycle): rsum == sum -> DONE; else -> ERROR.
- DONE: done_o=1, fetch_enable_o=1, busy_o=0, mem_req_o=0. Terminal until reset; start_i ignored.
- ERROR: error_o=1, fetch_enable_o=0. start_i restarts as from IDLE.
- busy_o = 1 in LOAD, VERIFY, CHECK.
- s_valid_i while s_ready_o=0 is ignored (not consumed).

## Timing
- start_i at edge 0 -> LOAD; s_ready_o=1 from cycle 1.
- Back-to-back beats: one RAM write per cycle, 1-cycle accept-to-write latency.
- Without verify, zero stall, N words: last beat edge at cycle N, last write cycle N+1, done_o/fetch_enable_o high from cycle N+2.
- With verify: reads cycles N+2..2N+1, last sample edge 2N+2, CHECK cycle 2N+2, done_o from cycle 2N+3 (or error_o).
- Reset asserted mid-operation: all outputs 0 immediately (async), mem_req_o drops in the same cycle; partial image left in RAM, no completion flagged.

## Configuration
- BOOTRAM_LOADER_VERIFY_EN defined: VERIFY and CHECK states, rsum register and read-back compiled in; error_o reachable.
- Undefined: LOAD -> DONE directly after last write; no read requests ever issued; mem_rdata_i unused; error_o tied 0.

## Test plan
- Verify undefined, len_i=3, words 0x800002b7, 0x00028313, 0x00028067 with no stalls -> writes at addr 0,1,2 on cycles 2,3,4, fetch_enable_o=1 from cycle 5.
- Stalls: s_valid_i low 2 cycles between each beat, len_i=2 -> mem_req_o=0 during gaps, exactly 2 writes, s_ready_o=0 after 2nd beat.
- len_i=0 -> DONE one cycle after start_i, no mem_req_o pulse; len_i=20 -> exactly 16 words accepted, addr 0..15, no wrap.
- Verify defined, RAM model correct, len_i=4 -> 4 writes then 4 reads addr 0..3, done_o=1 at cycle 2N+3=11, error_o=0.
- Verify defined, RAM model corrupts addr 1 readback (XOR 0x1) -> error_o=1, fetch_enable_o stays 0; new start_i clears error_o and reloads.
- rst_i pulsed after 2 of 4 beats -> all outputs 0 asynchronously, state IDLE; fresh start_i loads from addr 0.

Source files
------------

// File: rtl/bootram_loader.sv
// Boot RAM loader: streams instruction words into boot RAM, then releases core fetch.
// Optional read-back checksum verify is compiled in when BOOTRAM_LOADER_VERIFY_EN is defined.

module bootram_loader #(
    parameter int NUM_WORDS = 16,
    parameter int ADDR_W    = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [ADDR_W:0]   len_i,
    input  logic              s_valid_i,
    input  logic [31:0]       s_data_i,
    output logic              s_ready_o,
    output logic              mem_req_o,
    output logic              mem_wen_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_data_o,
    input  logic [31:0]       mem_rdata_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              error_o,
    output logic              fetch_enable_o
);

    localparam logic [ADDR_W:0] MAX_LEN = (ADDR_W+1)'(NUM_WORDS);
    localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W+1)'(1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_VERIFY = 3'd2,
        ST_CHECK  = 3'd3,
        ST_DONE   = 3'd4,
        ST_ERROR  = 3'd5
    } state_t;

    state_t            state_r;
    state_t            state_s;
    logic [ADDR_W:0]   len_clamp_s;
    logic [ADDR_W:0]   eff_len_r;
    logic [ADDR_W:0]   eff_len_s;
    logic [ADDR_W:0]   wr_cnt_r;
    logic [ADDR_W:0]   wr_cnt_s;
    logic              launch_s;
    logic              accept_s;

    logic              s_ready_r;
    logic              s_ready_s;
    logic              mem_req_r;
    logic              mem_req_s;
    logic              mem_wen_r;
    logic              mem_wen_s;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [ADDR_W-1:0] mem_addr_s;
    logic [31:0]       mem_data_r;
    logic [31:0]       mem_data_s;
    logic              busy_r;
    logic              busy_s;
    logic              done_r;
    logic              done_s;
    logic              fetch_r;
    logic              fetch_s;

`ifdef BOOTRAM_LOADER_VERIFY_EN
    logic [31:0]       sum_r;
    logic [31:0]       sum_s;
    logic [ADDR_W:0]   rd_cnt_r;
    logic [ADDR_W:0]   rd_cnt_s;
    logic [31:0]       rsum_r;
    logic [31:0]       rsum_s;
    logic [31:0]       rsum_final_s;
    logic              rd_pend_r;
    logic              rd_pend_s;
    logic              issue_rd_s;
    logic              check_ok_s;
    logic              error_r;
    logic              error_s;
`else
    logic              unused_rdata;
    assign unused_rdata = ^mem_rdata_i;
`endif

    // Clamp the requested length to the RAM depth
    always_comb begin
        if (len_i > MAX_LEN) begin
            len_clamp_s = MAX_LEN;
        end else begin
            len_clamp_s = len_i;
        end
    end

    assign launch_s = start_i && ((state_r == ST_IDLE) || (state_r == ST_ERROR));
    assign accept_s = s_valid_i && s_ready_r && (state_r == ST_LOAD);

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; LOAD exits only once the last write has been presented
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE, ST_ERROR: begin
                if (start_i) begin
                    if (len_clamp_s == '0) begin
                        state_s = ST_DONE;
                    end else begin
                        state_s = ST_LOAD;
                    end
                end else begin
                    state_s = state_r;
                end
            end
            ST_LOAD: begin
                if (wr_cnt_r == eff_len_r) begin
`ifdef BOOTRAM_LOADER_VERIFY_EN
                    state_s = ST_VERIFY;
`else
                    state_s = ST_DONE;
`endif
                end else begin
                    state_s = ST_LOAD;
                end
            end
`ifdef BOOTRAM_LOADER_VERIFY_EN
            ST_VERIFY: begin
                if (rd_cnt_r == eff_len_r) begin
                    state_s = ST_CHECK;
                end else begin
                    state_s = ST_VERIFY;
                end
            end
            ST_CHECK: begin
                if (check_ok_s) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_ERROR;
                end
            end
`endif
            ST_DONE: begin
                state_s = ST_DONE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Write-side counters: length latched on launch, count advances per accepted beat
    always_comb begin
        eff_len_s = eff_len_r;
        wr_cnt_s  = wr_cnt_r;
        if (launch_s) begin
            eff_len_s = len_clamp_s;
            wr_cnt_s  = '0;
        end else if (accept_s) begin
            wr_cnt_s  = wr_cnt_r + CNT_ONE;
        end else begin
            wr_cnt_s  = wr_cnt_r;
        end
    end

`ifdef BOOTRAM_LOADER_VERIFY_EN
    // Read-back path: a read issued in one cycle returns data to be summed one cycle later
    always_comb begin
        issue_rd_s   = (state_s == ST_VERIFY);
        rd_pend_s    = mem_req_r && !mem_wen_r;
        rsum_final_s = rd_pend_r ? (rsum_r + mem_rdata_i) : rsum_r;
        check_ok_s   = (rsum_final_s == sum_r);
        if (launch_s) begin
            sum_s    = 32'h0000_0000;
            rsum_s   = 32'h0000_0000;
            rd_cnt_s = '0;
        end else if (accept_s) begin
            sum_s    = sum_r + s_data_i;
            rsum_s   = rsum_final_s;
            rd_cnt_s = rd_cnt_r;
        end else if (issue_rd_s) begin
            sum_s    = sum_r;
            rsum_s   = rsum_final_s;
            rd_cnt_s = rd_cnt_r + CNT_ONE;
        end else begin
            sum_s    = sum_r;
            rsum_s   = rsum_final_s;
            rd_cnt_s = rd_cnt_r;
        end
    end

    // Verify datapath registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sum_r     <= 32'h0000_0000;
            rsum_r    <= 32'h0000_0000;
            rd_cnt_r  <= '0;
            rd_pend_r <= 1'b0;
            error_r   <= 1'b0;
        end else begin
            sum_r     <= sum_s;
            rsum_r    <= rsum_s;
            rd_cnt_r  <= rd_cnt_s;
            rd_pend_r <= rd_pend_s;
            error_r   <= error_s;
        end
    end
`endif

    // Write-side datapath registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            eff_len_r <= '0;
            wr_cnt_r  <= '0;
        end else begin
            eff_len_r <= eff_len_s;
            wr_cnt_r  <= wr_cnt_s;
        end
    end

    // Output decode from the upcoming state so every output can be registered
    always_comb begin
        s_ready_s  = (state_s == ST_LOAD) && (wr_cnt_s < eff_len_s);
        busy_s     = (state_s == ST_LOAD) || (state_s == ST_VERIFY) || (state_s == ST_CHECK);
        done_s     = (state_s == ST_DONE);
        fetch_s    = (state_s == ST_DONE);
`ifdef BOOTRAM_LOADER_VERIFY_EN
        error_s    = (state_s == ST_ERROR);
`endif
        mem_req_s  = 1'b0;
        mem_wen_s  = 1'b0;
        mem_addr_s = '0;
        mem_data_s = 32'h0000_0000;
        if (accept_s) begin
            mem_req_s  = 1'b1;
            mem_wen_s  = 1'b1;
            mem_addr_s = wr_cnt_r[ADDR_W-1:0];
            mem_data_s = s_data_i;
        end
`ifdef BOOTRAM_LOADER_VERIFY_EN
        else if (issue_rd_s) begin
            mem_req_s  = 1'b1;
            mem_wen_s  = 1'b0;
            mem_addr_s = rd_cnt_r[ADDR_W-1:0];
            mem_data_s = 32'h0000_0000;
        end
`endif
        else begin
            mem_req_s  = 1'b0;
        end
    end

    // Output registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s_ready_r  <= 1'b0;
            mem_req_r  <= 1'b0;
            mem_wen_r  <= 1'b0;
            mem_addr_r <= '0;
            mem_data_r <= 32'h0000_0000;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            fetch_r    <= 1'b0;
        end else begin
            s_ready_r  <= s_ready_s;
            mem_req_r  <= mem_req_s;
            mem_wen_r  <= mem_wen_s;
            mem_addr_r <= mem_addr_s;
            mem_data_r <= mem_data_s;
            busy_r     <= busy_s;
            done_r     <= done_s;
            fetch_r    <= fetch_s;
        end
    end

    assign s_ready_o      = s_ready_r;
    assign mem_req_o      = mem_req_r;
    assign mem_wen_o      = mem_wen_r;
    assign mem_addr_o     = mem_addr_r;
    assign mem_data_o     = mem_data_r;
    assign busy_o         = busy_r;
    assign done_o         = done_r;
    assign fetch_enable_o = fetch_r;
`ifdef BOOTRAM_LOADER_VERIFY_EN
    assign error_o        = error_r;
`else
    assign error_o        = 1'b0;
`endif

endmodule

// File: tb/tb_bootram_loader.sv
// Self-checking bench for bootram_loader: per-cycle compare against a timing-rule model
// plus hand-computed literal expectations; covers both builds of BOOTRAM_LOADER_VERIFY_EN.

module tb_bootram_loader;

    localparam int NW   = 16;
    localparam int AW   = 4;
    localparam int MAXC = 48;

`ifdef BOOTRAM_LOADER_VERIFY_EN
    localparam bit VER       = 1'b1;
    localparam int T1_DONE   = 9;
    localparam int T2_DONE   = 9;
    localparam int T4_DONE   = 35;
`else
    localparam bit VER       = 1'b0;
    localparam int T1_DONE   = 5;
    localparam int T2_DONE   = 6;
    localparam int T4_DONE   = 18;
`endif

    logic          clk = 1'b0;
    logic          rst_i;
    logic          start_i;
    logic [AW:0]   len_i;
    logic          s_valid_i;
    logic [31:0]   s_data_i;
    logic          s_ready_o;
    logic          mem_req_o;
    logic          mem_wen_o;
    logic [AW-1:0] mem_addr_o;
    logic [31:0]   mem_data_o;
    logic [31:0]   mem_rdata_i;
    logic          busy_o;
    logic          done_o;
    logic          error_o;
    logic          fetch_enable_o;

    bootram_loader #(.NUM_WORDS(NW), .ADDR_W(AW)) dut (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .len_i(len_i),
        .s_valid_i(s_valid_i), .s_data_i(s_data_i), .s_ready_o(s_ready_o),
        .mem_req_o(mem_req_o), .mem_wen_o(mem_wen_o), .mem_addr_o(mem_addr_o),
        .mem_data_o(mem_data_o), .mem_rdata_i(mem_rdata_i), .busy_o(busy_o),
        .done_o(done_o), .error_o(error_o), .fetch_enable_o(fetch_enable_o)
    );

    always #5 clk = ~clk;

    // Boot RAM model with optional readback corruption of one address
    logic [31:0] ram [NW];
    int          corrupt_addr;
    always @(posedge clk) begin
        if (mem_req_o && mem_wen_o) ram[mem_addr_o] <= mem_data_o;
        if (mem_req_o && !mem_wen_o)
            mem_rdata_i <= ram[mem_addr_o] ^ ((int'(mem_addr_o) == corrupt_addr) ? 32'h1 : 32'h0);
    end

    int          n_cmp;
    int          n_fail;
    logic [31:0] words [32];
    bit          vpat  [MAXC];
    bit          exp_ready [MAXC];
    bit          exp_req   [MAXC];
    bit          exp_wen   [MAXC];
    int          exp_addr  [MAXC];
    logic [31:0] exp_data  [MAXC];
    bit          exp_busy  [MAXC];
    bit          exp_done  [MAXC];
    bit          exp_err   [MAXC];
    int          first_done;
    int          first_err;
    int          nwr;
    int          nrd;

    task automatic check(input string name, input int r, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got 0x%08h expected 0x%08h", name, r, got, exp);
        end
    endtask

    // Expected per-cycle behaviour from the timing rules (cycle 1 follows the start edge)
    task automatic build_model(input int len);
        int eff;
        int acc;
        int last;
        int c;
        logic [31:0] s;
        logic [31:0] rs;
        for (int i = 0; i < MAXC; i++) begin
            exp_ready[i] = 0; exp_req[i] = 0; exp_wen[i] = 0; exp_addr[i] = 0;
            exp_data[i] = 32'h0; exp_busy[i] = 0; exp_done[i] = 0; exp_err[i] = 0;
        end
        eff = (len > NW) ? NW : len;
        if (eff == 0) begin
            for (int i = 1; i < MAXC; i++) exp_done[i] = 1;
            return;
        end
        acc = 0; last = 0; s = 32'h0;
        for (int e = 1; e < MAXC - 1 && acc < eff; e++) begin
            exp_ready[e] = 1;
            if (vpat[e]) begin
                exp_req[e+1] = 1; exp_wen[e+1] = 1; exp_addr[e+1] = acc;
                exp_data[e+1] = words[acc];
                s = s + words[acc];
                acc++;
                last = e;
            end
        end
        for (int i = 1; i <= last + 1; i++) exp_busy[i] = 1;
        if (!VER) begin
            for (int i = last + 2; i < MAXC; i++) exp_done[i] = 1;
        end else begin
            rs = 32'h0;
            for (int i = 0; i < eff; i++) begin
                c = last + 2 + i;
                exp_req[c] = 1; exp_wen[c] = 0; exp_addr[c] = i; exp_data[c] = 32'h0;
                rs = rs + (words[i] ^ ((i == corrupt_addr) ? 32'h1 : 32'h0));
            end
            for (int i = last + 2; i <= last + 2 + eff; i++) exp_busy[i] = 1;
            for (int i = last + 3 + eff; i < MAXC; i++) begin
                if (rs == s) exp_done[i] = 1;
                else exp_err[i] = 1;
            end
        end
    endtask

    task automatic compare_cycle(input int r);
        check("s_ready_o", r, {31'd0, s_ready_o}, {31'd0, exp_ready[r]});
        check("mem_req_o", r, {31'd0, mem_req_o}, {31'd0, exp_req[r]});
        if (exp_req[r]) begin
            check("mem_wen_o", r, {31'd0, mem_wen_o}, {31'd0, exp_wen[r]});
            check("mem_addr_o", r, 32'(mem_addr_o), 32'(exp_addr[r]));
            check("mem_data_o", r, mem_data_o, exp_data[r]);
        end
        check("busy_o", r, {31'd0, busy_o}, {31'd0, exp_busy[r]});
        check("done_o", r, {31'd0, done_o}, {31'd0, exp_done[r]});
        check("fetch_enable_o", r, {31'd0, fetch_enable_o}, {31'd0, exp_done[r]});
        check("error_o", r, {31'd0, error_o}, {31'd0, exp_err[r]});
        if (done_o === 1'b1 && first_done < 0) first_done = r;
        if (error_o === 1'b1 && first_err < 0) first_err = r;
        if (mem_req_o === 1'b1 && mem_wen_o === 1'b1) nwr++;
        if (mem_req_o === 1'b1 && mem_wen_o === 1'b0) nrd++;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " s_ready_o"}, 0, {31'd0, s_ready_o}, 32'd0);
        check({tag, " mem_req_o"}, 0, {31'd0, mem_req_o}, 32'd0);
        check({tag, " mem_wen_o"}, 0, {31'd0, mem_wen_o}, 32'd0);
        check({tag, " mem_addr_o"}, 0, 32'(mem_addr_o), 32'd0);
        check({tag, " mem_data_o"}, 0, mem_data_o, 32'd0);
        check({tag, " busy_o"}, 0, {31'd0, busy_o}, 32'd0);
        check({tag, " done_o"}, 0, {31'd0, done_o}, 32'd0);
        check({tag, " error_o"}, 0, {31'd0, error_o}, 32'd0);
        check({tag, " fetch_enable_o"}, 0, {31'd0, fetch_enable_o}, 32'd0);
    endtask

    // Start a load at the next edge, then drive beats and compare for ncyc cycles
    task automatic run_scn(input int len, input int ncyc, input int start2);
        int  ptr;
        bit  prev_v;
        bit  prev_r;
        build_model(len);
        @(negedge clk);
        start_i = 1'b1; len_i = (AW+1)'(len); s_valid_i = 1'b0;
        @(negedge clk);
        start_i = 1'b0;
        ptr = 0; prev_v = 0; prev_r = 0;
        first_done = -1; first_err = -1; nwr = 0; nrd = 0;
        for (int r = 1; r <= ncyc; r++) begin
            compare_cycle(r);
            if (prev_v && prev_r && ptr < 31) ptr++;
            s_valid_i = vpat[r];
            s_data_i  = words[ptr];
            start_i   = (r == start2);
            prev_v    = s_valid_i;
            prev_r    = s_ready_o;
            @(negedge clk);
        end
        s_valid_i = 1'b0;
        start_i   = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_i = 1'b1;
        @(negedge clk);
        rst_i = 1'b0;
    endtask

    task automatic set_vpat(input int from, input int to);
        for (int i = 0; i < MAXC; i++) vpat[i] = (i >= from && i <= to);
    endtask

    task automatic set_words(input logic [31:0] base);
        for (int i = 0; i < 32; i++) words[i] = base + 32'(i) * 32'h0001_0203;
    endtask

    initial begin
        n_cmp = 0; n_fail = 0; corrupt_addr = -1;
        rst_i = 1'b1; start_i = 1'b0; len_i = '0; s_valid_i = 1'b0; s_data_i = 32'h0;
        set_vpat(1, 0);
        set_words(32'hA500_0000);
        @(negedge clk);
        @(negedge clk);
        check_all_zero("reset");
        rst_i = 1'b0;

        // T1: three boot words, no stalls; late start_i while DONE is ignored
        words[0] = 32'h8000_02b7; words[1] = 32'h0002_8313; words[2] = 32'h0002_8067;
        set_vpat(1, 3);
        run_scn(3, 14, 12);
        check("t1 done cycle", 0, 32'(first_done), 32'(T1_DONE));
        check("t1 writes", 0, 32'(nwr), 32'd3);
        check("t1 ram0", 0, ram[0], 32'h8000_02b7);
        check("t1 ram1", 0, ram[1], 32'h0002_8313);
        check("t1 ram2", 0, ram[2], 32'h0002_8067);

        // T2: two beats with two idle cycles between, extra valid after the last is ignored
        do_reset();
        set_words(32'h1234_0000);
        set_vpat(1, 0); vpat[1] = 1; vpat[4] = 1; vpat[7] = 1;
        run_scn(2, 12, 0);
        check("t2 writes", 0, 32'(nwr), 32'd2);
        check("t2 done cycle", 0, 32'(first_done), 32'(T2_DONE));
        check("t2 ram1", 0, ram[1], 32'h1235_0203);

        // T3: zero length goes straight to DONE without RAM traffic
        do_reset();
        set_vpat(1, 6);
        run_scn(0, 6, 0);
        check("t3 done cycle", 0, 32'(first_done), 32'd1);
        check("t3 writes", 0, 32'(nwr), 32'd0);

        // T4: oversize length clamps to 16 words
        do_reset();
        set_words(32'h0BAD_0000);
        set_vpat(1, 40);
        run_scn(20, 40, 0);
        check("t4 writes", 0, 32'(nwr), 32'd16);
        check("t4 done cycle", 0, 32'(first_done), 32'(T4_DONE));
        check("t4 ram15", 0, ram[15], 32'h0BBC_1E2D);

        // T5: reset while the second write is on the bus, then a fresh load
        do_reset();
        set_words(32'h5500_0000);
        set_vpat(1, 2);
        run_scn(4, 2, 0);
        check("t5 req before reset", 0, {31'd0, mem_req_o}, 32'd1);
        rst_i = 1'b1;
        #1;
        check_all_zero("async reset");
        @(negedge clk);
        rst_i = 1'b0;
        check("t5 ram0 partial", 0, ram[0], 32'h5500_0000);
        set_words(32'h6600_0000);
        set_vpat(1, 3);
        run_scn(3, 14, 0);
        check("t5 reload done cycle", 0, 32'(first_done), 32'(T1_DONE));
        check("t5 reload ram0", 0, ram[0], 32'h6600_0000);

`ifdef BOOTRAM_LOADER_VERIFY_EN
        // T6: clean verify of four words
        do_reset();
        set_words(32'hC0DE_0000);
        set_vpat(1, 4);
        run_scn(4, 14, 0);
        check("t6 done cycle", 0, 32'(first_done), 32'd11);
        check("t6 reads", 0, 32'(nrd), 32'd4);

        // T7: corrupted readback at addr 1 flags error; restart from ERROR reloads
        do_reset();
        corrupt_addr = 1;
        run_scn(4, 14, 0);
        check("t7 error cycle", 0, 32'(first_err), 32'd11);
        check("t7 done seen", 0, 32'(first_done), 32'hFFFF_FFFF);
        corrupt_addr = -1;
        run_scn(4, 14, 0);
        check("t7 restart done cycle", 0, 32'(first_done), 32'd11);
        check("t7 restart error seen", 0, 32'(first_err), 32'hFFFF_FFFF);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
